// File: rtl/dec_scan_if.sv
// dec_scan_if -- bundles the control and result signals of dec_scan.
//
// Handshake note: there is no valid/ready pair on this bus. The controls
// (x_in, mode, en, load, blank) are sampled on every rising clock edge, and
// the results (y_out, idx_out, wrap) are registered. A consumer may read the
// results at any time away from the clock edge.
//
// Signals:
//   x_in    [N-1:0]   select in direct mode, start index for load
//   mode              0 = direct decode, 1 = auto-scan
//   en                1 = advance/update, 0 = freeze
//   load              load x_in into the scan index
//   blank             force outputs dark, return to IDLE
//   y_out   [2^N-1:0] registered one-hot decode
//   idx_out [N-1:0]   current active index
//   wrap              one-cycle pulse on scan wrap-around
//   state   [1:0]     FSM state, for debug (0 IDLE, 1 DIRECT, 2 SCAN)
//   dwell   [7:0]     dwell counter, for debug
interface dec_scan_if #(
   parameter int N = 3
) ();
   logic [N-1:0]      x_in;
   logic              mode;
   logic              en;
   logic              load;
   logic              blank;
   logic [(1<<N)-1:0] y_out;
   logic [N-1:0]      idx_out;
   logic              wrap;
   logic [1:0]        state;
   logic [7:0]        dwell;

   modport master (
      output x_in, mode, en, load, blank,
      input  y_out, idx_out, wrap, state, dwell
   );

   modport slave (
      input  x_in, mode, en, load, blank,
      output y_out, idx_out, wrap, state, dwell
   );
endinterface

// File: rtl/dec_scan.sv
// dec_scan -- N-to-2^N decoder with direct-decode and auto-scan modes.
//
// In DIRECT the registered one-hot output follows x_in with one clock of
// latency. In SCAN the active index advances by one every DWELL enabled
// cycles, wrapping modulo 2^N and pulsing wrap for one cycle on wrap-around.
// Edge priority: rst > blank > load > en-driven update.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  dec_scan_if slave modport (controls in, y_out/idx_out/wrap out,
//        plus state and dwell for debug)
module dec_scan #(
   parameter int N     = 3,
   parameter int DWELL = 4
) (
   input logic     clk,
   input logic     rst,
   dec_scan_if.slave bus
);
   localparam int         W    = 1 << N;
   localparam logic [7:0] LAST = 8'(DWELL - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t         state_q;
   logic [N-1:0]   idx_q;
   logic [7:0]     dwell_q;
   logic [W-1:0]   y_q;
   logic           wrap_q;

   function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
      logic [W-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         dwell_q <= '0;
         y_q     <= '0;
         wrap_q  <= 1'b0;
      end else if (bus.blank) begin
         // idx is deliberately kept so a later scan resumes where it was
         state_q <= IDLE;
         dwell_q <= '0;
         y_q     <= '0;
         wrap_q  <= 1'b0;
      end else if (bus.load) begin
         // load ignores en and never signals a wrap, even when it moves
         // the index from the top value to zero
         state_q <= bus.mode ? SCAN : DIRECT;
         idx_q   <= bus.x_in;
         dwell_q <= '0;
         y_q     <= onehot(bus.x_in);
         wrap_q  <= 1'b0;
      end else if (!bus.en) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         case (state_q)
            IDLE, DIRECT: begin
               if (!bus.mode) begin
                  // leaving IDLE for DIRECT decodes on the same edge, so
                  // the first x_in already appears one clock later
                  state_q <= DIRECT;
                  idx_q   <= bus.x_in;
                  dwell_q <= '0;
                  y_q     <= onehot(bus.x_in);
               end else begin
                  // entering SCAN keeps the current index and starts a
                  // fresh dwell period
                  state_q <= SCAN;
                  dwell_q <= '0;
                  y_q     <= onehot(idx_q);
               end
            end
            SCAN: begin
               if (!bus.mode) begin
                  state_q <= DIRECT;
                  dwell_q <= '0;
                  y_q     <= onehot(idx_q);
               end else if (dwell_q == LAST) begin
                  idx_q   <= idx_q + 1'b1;
                  dwell_q <= '0;
                  y_q     <= onehot(idx_q + 1'b1);
                  wrap_q  <= (idx_q == {N{1'b1}});
               end else begin
                  dwell_q <= dwell_q + 8'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               dwell_q <= '0;
               y_q     <= '0;
            end
         endcase
      end
   end

   assign bus.y_out   = y_q;
   assign bus.idx_out = idx_q;
   assign bus.wrap    = wrap_q;
   assign bus.state   = state_q;
   assign bus.dwell   = dwell_q;
endmodule

// File: doc/dec_scan.md
DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning select width (decoder is N-to-2^N), legal range 1..6.
REQ-002 The block SHALL have parameter DWELL, default 4, meaning clock cycles per scan step, legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port x_in, input, N, decode select in direct mode and start index for load.
REQ-006 The block SHALL have port mode, input, 1: 0 = direct decode, 1 = auto-scan.
REQ-007 The block SHALL have port en, input, 1: 1 = advance/update, 0 = freeze all state.
REQ-008 The block SHALL have port load, input, 1: load x_in into the scan index.
REQ-009 The block SHALL have port blank, input, 1: force outputs dark and return to IDLE.
REQ-010 The block SHALL have port y_out, output, 2^N, registered one-hot decoder output.
REQ-011 The block SHALL have port idx_out, output, N, current active index.
REQ-012 The block SHALL have port wrap, output, 1, one-cycle pulse on scan wrap-around.

Function
REQ-013 The FSM SHALL have states IDLE, DIRECT and SCAN; IDLE drives y_out = 0.
REQ-014 Priority per edge SHALL be rst > blank > load > en-driven update.
REQ-015 In IDLE: en=1 with mode=0 SHALL go to DIRECT; en=1 with mode=1 SHALL go to SCAN; otherwise stay in IDLE.
REQ-016 In DIRECT or SCAN, a change of mode with en=1 SHALL switch to the other run state on that edge, keeping idx and clearing the dwell counter.
REQ-017 blank=1 SHALL, on the next edge, set state to IDLE, y_out to 0, wrap to 0 and the dwell counter to 0, with idx unchanged.
REQ-018 DIRECT with en=1 SHALL give idx <= x_in and y_out <= one-hot(x_in), a latency of exactly 1 clock.
REQ-019 SCAN with en=1 SHALL increment the dwell counter each cycle; at dwell == DWELL-1 it SHALL set idx <= idx+1 mod 2^N and reset dwell to 0.
REQ-020 In SCAN, y_out SHALL equal one-hot(idx) registered, changing on the same edge as idx.
REQ-021 wrap SHALL be 1 for exactly the cycle after idx steps from 2^N-1 to 0 in SCAN, and 0 at all other times.
REQ-022 load=1 (any non-reset state, en ignored) SHALL set idx <= x_in, dwell <= 0 and y_out <= one-hot(x_in); it SHALL NOT assert wrap, and an IDLE state SHALL move to DIRECT or SCAN per mode.
REQ-023 en=0 SHALL hold state, idx, dwell and y_out, and SHALL force wrap to 0.
REQ-024 With DWELL=1, SCAN SHALL step idx every enabled cycle.
REQ-025 y_out SHALL never have more than one bit set; out-of-range parameters are a configuration error and need not be handled.

Reset
REQ-026 rst=1 SHALL, on the next edge, set state to IDLE, y_out to 0, idx_out to 0, wrap to 0 and dwell to 0, regardless of other inputs and including mid-scan.
REQ-027 While rst is held, outputs SHALL remain at their reset values; the first update occurs on the edge after rst is sampled low.

Verification
REQ-028 N=3, reset then mode=0, en=1, x_in stepping 0..7, one value per cycle -> y_out = 0x01, 0x02 ... 0x80, each one clock after x_in is applied.
REQ-029 N=3, DWELL=4, mode=1, en=1 from IDLE -> idx 0,1,...,7,0 with 4 cycles per step; wrap high exactly one cycle when idx returns to 0 and y_out = 0x01.
REQ-030 In SCAN at idx=5, en=0 for 10 cycles, then en=1 -> idx stays 5 and y_out = 0x20 throughout the freeze; the dwell count resumes where it stopped.
REQ-031 In SCAN, load=1 with x_in=6 and blank=0 -> next cycle idx=6, y_out=0x40, dwell=0, wrap=0; with load=1 and blank=1 together -> IDLE, y_out=0, idx unchanged.
REQ-032 rst asserted mid-scan at idx=7, simultaneously with load=1 -> next cycle y_out=0, idx_out=0, wrap=0, state IDLE.
REQ-033 Every cycle, check by assertion that y_out is one-hot or zero, and that y_out equals one-hot(idx_out) whenever the state is not IDLE.
